// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARMv4 control unit: FSM states, ALU
// operation codes, data-processing cmd values and condition codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       supported;
    logic       is_cmp;
    logic       sets_cv;
    logic [3:0] alu;
  } dp_op_t;

  // Data-processing cmd decode; unsupported cmds execute as a no-op.
  function automatic dp_op_t decode_cmd(input logic [3:0] cmd);
    dp_op_t d;
    d = '{supported: 1'b1, is_cmp: 1'b0, sets_cv: 1'b0, alu: ALU_ADD};
    case (cmd)
      CMD_AND: d.alu = ALU_AND;
      CMD_EOR: d.alu = ALU_EOR;
      CMD_SUB: begin d.alu = ALU_SUB; d.sets_cv = 1'b1; end
      CMD_ADD: begin d.alu = ALU_ADD; d.sets_cv = 1'b1; end
      CMD_CMP: begin d.alu = ALU_SUB; d.sets_cv = 1'b1; d.is_cmp = 1'b1; end
      CMD_ORR: d.alu = ALU_ORR;
      CMD_MOV: d.alu = ALU_MOV;
      default: d.supported = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the NZCV flags ({N,Z,C,V}).
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111 never executes
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Step sequencer for the multicycle ARMv4 datapath: state, NZCV flags,
// condition check and all datapath selects / write enables.
module multicycle_control_fsm
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  Flags
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit;
  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign i_bit = Instr[13];
  assign cmd   = Instr[12:9];
  assign u_bit = Instr[11];
  assign s_bit = Instr[8];
  assign rd    = Instr[3:0];

  // Rn is consumed by the datapath only.
  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

  state_t     state;
  logic [3:0] flags_q;
  logic       cond_ex;
  dp_op_t     dp;

  assign dp    = decode_cmd(cmd);
  assign Flags = flags_q;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // NOTE: reset is sampled only on the clock edge, so rst appears inside the
  // clocked block rather than in its sensitivity list; all state uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      flags_q <= RESET_FLAGS;
    end else begin
      case (state)
        FETCH:  if (MemReady) state <= DECODE;
        DECODE: begin
          if (!cond_ex) state <= FETCH;
          else begin
            case (op)
              OP_MEM:  state <= MEMADR;
              OP_DP:   state <= i_bit ? EXECI : EXECR;
              OP_BR:   state <= BRANCH;
              default: state <= FETCH;
            endcase
          end
        end
        MEMADR: state <= s_bit ? MEMRD : MEMWR;
        MEMRD:  if (MemReady) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (MemReady) state <= FETCH;
        EXECR, EXECI: begin
          state <= ALUWB;
          // C and V are only meaningful for the arithmetic ops.
          if (dp.supported && (s_bit || dp.is_cmp)) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dp.sets_cv) flags_q[1:0] <= ALUFlags[1:0];
          end
        end
        ALUWB:   state <= FETCH;
        BRANCH:  state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR:  ALUControl = dp.alu;
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dp.alu;
      end
      ALUWB: begin
        // A write to R15 is a jump: it goes to the PC, not the register file.
        if (dp.supported && !dp.is_cmp) begin
          if (rd == 4'd15) PCWrite  = 1'b1;
          else             RegWrite = 1'b1;
        end
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_DP:   ImmSrc = 2'b00;
      OP_MEM:  ImmSrc = 2'b01;
      default: ImmSrc = 2'b10;
    endcase
  end

  assign RegSrc = {op == OP_MEM, op == OP_BR};

endmodule
